// File: rtl/icache_responder.sv
// -----------------------------------------------------------------------------
// icache_responder
//   Responder end of the instruction-memory interface. A small direct-mapped,
//   read-only instruction cache with 32-byte lines. Hits are answered in the
//   request cycle. A miss fetches one full line from physical memory, installs
//   it, and then answers from that line in a single REPLY cycle.
//
// Ports
//   clk            in   clock, all state updates on the rising edge
//   rst            in   asynchronous active-high reset
//   i_mem_read     in   fetch request, held with a stable address until resp
//   i_mem_address  in   fetch byte address, bits [1:0] ignored
//   i_mem_resp     out  one-cycle pulse, i_mem_rdata valid in that cycle
//   i_mem_rdata    out  instruction word (zero whenever i_mem_resp is low)
//   flush          in   invalidate every line at the next edge
//   pmem_read      out  line-fill request, held until pmem_resp
//   pmem_address   out  line-aligned fill address
//   pmem_resp      in   one-cycle pulse, pmem_rdata valid
//   pmem_rdata     in   fill line, word k in bits [32k+31:32k]
// -----------------------------------------------------------------------------
module icache_responder #(
  parameter int width   = 32,
  parameter int s_index = 3,
  parameter int s_line  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic [31:0]       i_mem_address,
  output logic              i_mem_resp,
  output logic [width-1:0]  i_mem_rdata,
  input  logic              flush,
  output logic              pmem_read,
  output logic [31:0]       pmem_address,
  input  logic              pmem_resp,
  input  logic [s_line-1:0] pmem_rdata
);

  localparam int sets  = 2 ** s_index;
  localparam int tag_w = 32 - 5 - s_index;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    REPLY = 2'd2
  } state_t;

  state_t             state_q;
  logic [sets-1:0]    valid_q;
  logic [sets-1:0]    valid_d;
  logic [tag_w-1:0]   tag_q  [sets];
  logic [s_line-1:0]  line_q [sets];
  logic [31:0]        line_addr_q;

  logic [s_index-1:0] req_index;
  logic [tag_w-1:0]   req_tag;
  logic [7:0]         word_off;
  logic [s_line-1:0]  sel_line;
  logic [width-1:0]   sel_word;
  logic               hit;
  logic               reply_ok;
  logic               fill_we;
  logic [s_index-1:0] fill_index;
  logic [sets-1:0]    fill_onehot;

  assign req_index  = i_mem_address[4+s_index:5];
  assign req_tag    = i_mem_address[31:5+s_index];
  assign fill_index = line_addr_q[4+s_index:5];

  // Bit offset of the selected word in the line; the byte offset bits [1:0]
  // are masked to zero so they never influence the selection.
  assign word_off = {i_mem_address[4:2], 5'b00000} |
                    {3'b000, i_mem_address[1:0] & 2'b00, 3'b000};

  // In REPLY the requested address lies in the line just written at the
  // latched index, so the same request-indexed read path serves both states.
  assign sel_line = line_q[req_index];
  assign sel_word = sel_line[word_off +: width];

  assign hit      = i_mem_read & valid_q[req_index] & (tag_q[req_index] == req_tag);
  assign reply_ok = i_mem_read & (i_mem_address[31:5] == line_addr_q[31:5]);
  assign fill_we  = (state_q == FILL) & pmem_resp;

  // Decoded from the state register, so reset removes the fill request at once.
  assign pmem_read    = (state_q == FILL);
  assign pmem_address = line_addr_q;

  // Response decode: hits answer combinationally in IDLE, a completed fill
  // answers in REPLY only if the requester is still asking for that line.
  always_comb begin
    i_mem_resp  = 1'b0;
    i_mem_rdata = {width{1'b0}};
    case (state_q)
      IDLE:    i_mem_resp = hit;
      REPLY:   i_mem_resp = reply_ok;
      default: i_mem_resp = 1'b0;
    endcase
    if (i_mem_resp) begin
      i_mem_rdata = sel_word;
    end else begin
      i_mem_rdata = {width{1'b0}};
    end
  end

  // Next valid vector: flush clears everything, a fill landing in the same
  // cycle still marks its own set valid.
  always_comb begin
    fill_onehot = {{(sets-1){1'b0}}, 1'b1} << fill_index;
    valid_d     = (flush ? {sets{1'b0}} : valid_q) | (fill_we ? fill_onehot : {sets{1'b0}});
  end

  // Controller: state, valid bits and the latched line address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= {sets{1'b0}};
      line_addr_q <= 32'h0000_0000;
    end else begin
      valid_q <= valid_d;
      case (state_q)
        IDLE: begin
          if (i_mem_read && !hit) begin
            line_addr_q <= {i_mem_address[31:5], 5'b00000};
            state_q     <= FILL;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            state_q <= REPLY;
          end
        end
        REPLY:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line and tag storage; written only when a fill returns.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_index]  <= line_addr_q[31:5+s_index];
      line_q[fill_index] <= pmem_rdata;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
module tb_icache_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_mem_read;
  logic [31:0]  i_mem_address;
  logic         i_mem_resp;
  logic [31:0]  i_mem_rdata;
  logic         flush;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic         pmem_resp = 1'b0;
  logic [255:0] pmem_rdata = '0;

  int          checks = 0;
  int          errors = 0;
  int          resp_cnt = 0;
  int          pread_cnt = 0;
  logic [31:0] last_paddr = 32'h0;
  bit          pmem_en = 1'b1;
  bit          pmem_late = 1'b0;

  // behavioural model of cache contents and the miss sequence
  int          m_phase = 0;
  bit          m_valid [8];
  logic [26:0] m_ltag  [8];
  logic [31:0] m_line = 32'h0;

  icache_responder dut (
    .clk           (clk),
    .rst           (rst),
    .i_mem_read    (i_mem_read),
    .i_mem_address (i_mem_address),
    .i_mem_resp    (i_mem_resp),
    .i_mem_rdata   (i_mem_rdata),
    .flush         (flush),
    .pmem_read     (pmem_read),
    .pmem_address  (pmem_address),
    .pmem_resp     (pmem_resp),
    .pmem_rdata    (pmem_rdata)
  );

  always #5 clk = ~clk;

  // memory image: word at byte address 0x60 is 0x1000_0000, +1 per word
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]} - 32'h0000_0018;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = mem_word({a[31:5], 5'b00000} + 32'(4 * k));
    return l;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // one-cycle physical memory (responds in the first cycle pmem_read is seen)
  always @(posedge clk) begin
    #2;
    if (pmem_late) begin
      pmem_resp  = 1'b1;
      pmem_rdata = mem_line(32'h0000_0200);
    end else if (pmem_read && pmem_en) begin
      pmem_resp  = 1'b1;
      pmem_rdata = mem_line(pmem_address);
    end else begin
      pmem_resp  = 1'b0;
    end
  end

  // per-cycle compare against the model, then advance the model
  always @(negedge clk) begin
    logic [31:0] a;
    logic [2:0]  s;
    bit          hit, exp_resp, exp_pread;
    if (rst) begin
      check("rst_resp",  32'(i_mem_resp), 32'h0);
      check("rst_pread", 32'(pmem_read), 32'h0);
      check("rst_rdata", i_mem_rdata, 32'h0);
      check("rst_paddr", pmem_address, 32'h0);
      m_phase = 0;
      for (int k = 0; k < 8; k++) m_valid[k] = 1'b0;
    end else begin
      a   = i_mem_address;
      s   = a[7:5];
      hit = i_mem_read && m_valid[s] && (m_ltag[s] == a[31:5]);
      exp_resp  = 1'b0;
      exp_pread = 1'b0;
      case (m_phase)
        0:       exp_resp  = hit;
        1:       exp_pread = 1'b1;
        2:       exp_resp  = i_mem_read && (a[31:5] == m_line[31:5]);
        default: exp_resp  = 1'b0;
      endcase
      check("resp",  32'(i_mem_resp), 32'(exp_resp));
      if (exp_resp) check("rdata", i_mem_rdata, mem_word(a));
      check("pread", 32'(pmem_read), 32'(exp_pread));
      if (exp_pread) check("paddr", pmem_address, m_line);
      if (i_mem_resp) resp_cnt++;
      if (pmem_read) begin
        pread_cnt++;
        last_paddr = pmem_address;
      end
      if (flush) for (int k = 0; k < 8; k++) m_valid[k] = 1'b0;
      case (m_phase)
        0: if (i_mem_read && !hit) begin
             m_line  = {a[31:5], 5'b00000};
             m_phase = 1;
           end
        1: if (pmem_resp) begin
             m_valid[m_line[7:5]] = 1'b1;
             m_ltag[m_line[7:5]]  = m_line[31:5];
             m_phase = 2;
           end
        default: m_phase = 0;
      endcase
    end
  end

  // hold a request until resp (bounded); flush is raised during cycle fc (1-based)
  task automatic fetch(input logic [31:0] a, input int fc, output int lat, output logic [31:0] d);
    bit got = 1'b0;
    lat = 0;
    d   = 32'h0;
    i_mem_read    = 1'b1;
    i_mem_address = a;
    while (!got && lat < 20) begin
      flush = (lat + 1 == fc);
      @(negedge clk);
      lat++;
      if (i_mem_resp) begin
        got = 1'b1;
        d   = i_mem_rdata;
      end
      @(posedge clk);
      #1;
    end
    flush      = 1'b0;
    i_mem_read = 1'b0;
    check("resp_timeout", 32'(got), 32'h1);
  endtask

  task automatic expect_fetch(input string name, input logic [31:0] a, input int fc,
                              input int exp_lat, input logic [31:0] exp_data);
    int          lat;
    logic [31:0] d;
    fetch(a, fc, lat, d);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_data"}, d, exp_data);
  endtask

  initial begin
    int p0, r0;
    rst = 1'b1;
    i_mem_read = 1'b0;
    i_mem_address = 32'h0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_pread", 32'(pmem_read), 32'h0);

    // cold miss
    p0 = pread_cnt;
    expect_fetch("cold", 32'h0000_0060, 0, 3, 32'h1000_0000);
    check("cold_pread_cycles", 32'(pread_cnt - p0), 32'h1);
    check("cold_paddr", last_paddr, 32'h0000_0060);

    // streaming hits through the rest of the line
    p0 = pread_cnt;
    for (int k = 1; k < 8; k++)
      expect_fetch("stream", 32'h0000_0060 + 32'(4 * k), 0, 1, 32'h1000_0000 + 32'(k));
    check("stream_no_pread", 32'(pread_cnt - p0), 32'h0);

    // next line after word 7
    expect_fetch("wrap", 32'h0000_0080, 0, 3, 32'h1000_0008);
    check("wrap_paddr", last_paddr, 32'h0000_0080);
    expect_fetch("wrap_old", 32'h0000_0060, 0, 1, 32'h1000_0000);

    // conflict miss on index 3
    expect_fetch("conflict", 32'h0000_0160, 0, 3, 32'h1000_0040);
    check("conflict_paddr", last_paddr, 32'h0000_0160);
    expect_fetch("conflict_old", 32'h0000_0060, 0, 3, 32'h1000_0000);

    // plain flush pulse
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    expect_fetch("flush_miss", 32'h0000_0060, 0, 3, 32'h1000_0000);

    // flush coinciding with pmem_resp
    expect_fetch("flush_fill", 32'h0000_0080, 2, 3, 32'h1000_0008);
    expect_fetch("flush_fill_hit", 32'h0000_0084, 0, 1, 32'h1000_0009);
    expect_fetch("flush_fill_other", 32'h0000_0060, 0, 3, 32'h1000_0000);

    // hit served in the flush cycle, invalid afterwards
    expect_fetch("flush_hit", 32'h0000_0064, 1, 1, 32'h1000_0001);
    expect_fetch("flush_hit_after", 32'h0000_0064, 0, 3, 32'h1000_0001);

    // requester drops before REPLY: no resp, line still installed
    r0 = resp_cnt;
    i_mem_read = 1'b1;
    i_mem_address = 32'h0000_00A0;
    @(posedge clk);
    #1;
    i_mem_read = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("drop_no_resp", 32'(resp_cnt - r0), 32'h0);
    expect_fetch("drop_installed", 32'h0000_00A4, 0, 1, 32'h1000_0011);

    // reset in the middle of a fill
    pmem_en = 1'b0;
    i_mem_read = 1'b1;
    i_mem_address = 32'h0000_0200;
    @(posedge clk);
    #1;
    check("midfill_pread", 32'(pmem_read), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_pread_async", 32'(pmem_read), 32'h0);
    check("rst_no_resp", 32'(i_mem_resp), 32'h0);
    i_mem_read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    r0 = resp_cnt;
    p0 = pread_cnt;
    pmem_late = 1'b1;
    @(posedge clk);
    #1;
    pmem_late = 1'b0;
    @(posedge clk);
    #1;
    check("late_no_resp", 32'(resp_cnt - r0), 32'h0);
    check("late_no_pread", 32'(pread_cnt - p0), 32'h0);
    pmem_en = 1'b1;
    expect_fetch("after_rst", 32'h0000_0200, 0, 3, 32'h1000_0068);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
